// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - DVP byte capture, RGB565 pairing and FIFO write stage
module cam_pixel_capture #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int SKIP_FRAMES = 2,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_en,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    input  logic             fifo_full,
    input  logic             clr_status,
    output logic             fifo_write,
    output logic [15:0]      fifo_data,
    output logic             frame_active,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [CNT_W-1:0] line_count,
    output logic             overflow,
    output logic             line_error
);
    typedef enum logic [1:0] {S_SYNC, S_SKIP, S_ACTIVE, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [15:0]      SKIP_C  = 16'(SKIP_FRAMES);

    // Counters must be able to hold a full line and a full frame.
    if (IMG_WIDTH > 2**CNT_W - 1 || IMG_HEIGHT > 2**CNT_W - 1) begin : g_cnt_w_check
        $error("CNT_W too narrow for IMG_WIDTH/IMG_HEIGHT");
    end

    state_t           state;
    logic             vsync_q, href_q, vsync_prev, href_prev;
    logic [7:0]       data_q;
    logic [15:0]      skip_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic             phase;
    logic [7:0]       hi_byte;
    logic             pair_valid;
    logic [15:0]      pair_data;
    logic             wr_pend;
    logic             frame_start;
    logic             line_end;
    logic             line_bad;
    logic             drop;

    logic vs_fall, vs_rise, href_rise, href_fall;
    assign vs_fall   = vsync_prev & ~vsync_q;
    assign vs_rise   = ~vsync_prev & vsync_q;
    assign href_rise = ~href_prev & href_q;
    assign href_fall = href_prev & ~href_q;

    assign line_end   = (state == S_ACTIVE) && href_fall;
    assign line_bad   = line_end && ((pix_cnt != WIDTH_C) || phase);
    assign drop       = wr_pend & fifo_full;
    assign fifo_write = wr_pend & ~fifo_full;

    // Pin register stage plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= 8'h00;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
        end else begin
            vsync_q    <= cam_vsync;
            href_q     <= cam_href;
            data_q     <= cam_data;
            vsync_prev <= vsync_q;
            href_prev  <= href_q;
        end
    end

    // A captured frame begins on a vsync fall from SYNC (no skip), the last SKIP edge, or WAIT
    always_comb begin
        frame_start = 1'b0;
        if (vs_fall && capture_en) begin
            case (state)
                S_SYNC:  frame_start = (SKIP_FRAMES == 0);
                S_SKIP:  frame_start = (skip_cnt == SKIP_C);
                S_WAIT:  frame_start = 1'b1;
                default: frame_start = 1'b0;
            endcase
        end
    end

    // Frame FSM, byte pairing and line/frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SYNC;
            skip_cnt     <= 16'd0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
            line_count   <= '0;
            pix_cnt      <= '0;
            phase        <= 1'b0;
            hi_byte      <= 8'h00;
            pair_valid   <= 1'b0;
            pair_data    <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            pair_valid <= 1'b0;
            if (frame_start) begin
                state        <= S_ACTIVE;
                frame_active <= 1'b1;
                line_count   <= '0;
                pix_cnt      <= '0;
                phase        <= 1'b0;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (vs_fall && capture_en) begin
                            state    <= S_SKIP;
                            skip_cnt <= 16'd1;
                        end
                    end
                    S_SKIP: begin
                        if (vs_fall) begin
                            if (!capture_en) state <= S_SYNC;
                            else             skip_cnt <= skip_cnt + 16'd1;
                        end
                    end
                    S_WAIT: begin
                        if (vs_fall) state <= S_SYNC;
                    end
                    S_ACTIVE: begin
                        if (href_q) begin
                            if (href_rise || !phase) begin
                                hi_byte <= data_q;
                                phase   <= 1'b1;
                            end else begin
                                pair_valid <= 1'b1;
                                pair_data  <= {hi_byte, data_q};
                                phase      <= 1'b0;
                                if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_W'(1);
                            end
                        end
                        if (href_fall) begin
                            if (line_count != CNT_MAX) line_count <= line_count + CNT_W'(1);
                            pix_cnt <= '0;
                            phase   <= 1'b0;
                        end
                        if (vs_rise) begin
                            frame_done   <= 1'b1;
                            frame_count  <= frame_count + 16'd1;
                            frame_active <= 1'b0;
                            state        <= S_WAIT;
                        end
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end

    // Write stage: holds the pixel for the strobe cycle, gated by fifo_full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend   <= 1'b0;
            fifo_data <= 16'h0000;
        end else begin
            wr_pend <= pair_valid;
            if (pair_valid) fifo_data <= pair_data;
        end
    end

    // Sticky error flags; a set event in the same cycle beats clr_status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            line_error <= 1'b0;
        end else begin
            if (drop)            overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
            if (line_bad)        line_error <= 1'b1;
            else if (clr_status) line_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_en = 1'b0;
    logic cam_vsync = 1'b1;
    logic cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic fifo_full = 1'b0;
    logic clr_status = 1'b0;

    logic          fw    [2];
    logic [15:0]   fd    [2];
    logic          fa    [2];
    logic          fdone [2];
    logic [15:0]   fc    [2];
    logic [CW-1:0] lc    [2];
    logic          ovf   [2];
    logic          lerr  [2];

    cam_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(0), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .fifo_full(fifo_full), .clr_status(clr_status),
        .fifo_write(fw[0]), .fifo_data(fd[0]), .frame_active(fa[0]), .frame_done(fdone[0]),
        .frame_count(fc[0]), .line_count(lc[0]), .overflow(ovf[0]), .line_error(lerr[0]));

    cam_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(2), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .fifo_full(fifo_full), .clr_status(clr_status),
        .fifo_write(fw[1]), .fifo_data(fd[1]), .frame_active(fa[1]), .frame_done(fdone[1]),
        .frame_count(fc[1]), .line_count(lc[1]), .overflow(ovf[1]), .line_error(lerr[1]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] act_q [2][$];
    int          done_cnt [2];

    // reference model state
    bit          armed  [2];
    int          left   [2];
    bit          capt   [2];
    int          m_fc   [2];
    int          m_lc   [2];
    bit          m_ovf  [2];
    bit          m_lerr [2];
    int          m_done [2];
    logic [15:0] exp_q  [2][$];

    // frame description
    int         nlines;
    int         ln_len  [4];
    logic [7:0] ln_b    [4][16];
    bit         ln_full [4][16];

    typedef struct {
        int len0;
        int len1;
        int full_off;
        bit en;
        bit drop;
        bit clr;
        int wr_a;
        int wr_b;
        bit ovf;
        bit lerr;
    } vec_t;
    vec_t tbl [10];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fw[d] === 1'b1) act_q[d].push_back(fd[d]);
            if (fdone[d] === 1'b1) done_cnt[d]++;
        end
    end

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic int skip_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            armed[d] = 0; left[d] = 0; capt[d] = 0;
            m_fc[d] = 0; m_lc[d] = 0; m_ovf[d] = 0; m_lerr[d] = 0; m_done[d] = 0;
            exp_q[d].delete();
            act_q[d].delete();
            done_cnt[d] = 0;
        end
    endtask

    task automatic model_frame_start(input bit en);
        for (int d = 0; d < 2; d++) begin
            if (armed[d] && !en) armed[d] = 0;
            if (!armed[d] && en) begin
                armed[d] = 1;
                left[d] = skip_of(d);
            end
            capt[d] = 0;
            if (armed[d]) begin
                if (left[d] > 0) left[d]--;
                else begin
                    capt[d] = 1;
                    m_lc[d] = 0;
                end
            end
        end
    endtask

    task automatic model_frame_body;
        for (int d = 0; d < 2; d++) begin
            if (capt[d]) begin
                for (int l = 0; l < nlines; l++) begin
                    for (int p = 0; p < ln_len[l] / 2; p++) begin
                        if (ln_full[l][2*p+4]) m_ovf[d] = 1;
                        else exp_q[d].push_back({ln_b[l][2*p], ln_b[l][2*p+1]});
                    end
                    if (m_lc[d] < 2047) m_lc[d]++;
                    if (ln_len[l] != 2 * W) m_lerr[d] = 1;
                end
                m_fc[d] = (m_fc[d] + 1) % 65536;
                m_done[d]++;
            end
        end
    endtask

    task automatic pulse_clr;
        clr_status = 1'b1;
        tick;
        clr_status = 1'b0;
        tick;
        for (int d = 0; d < 2; d++) begin
            m_ovf[d] = 0;
            m_lerr[d] = 0;
        end
    endtask

    task automatic drive_frame(input bit en_start, input bit drop_en);
        capture_en = en_start;
        tick;
        tick;
        model_frame_start(en_start);
        cam_vsync = 1'b0;
        repeat (3) tick;
        for (int l = 0; l < nlines; l++) begin
            for (int j = 0; j < ln_len[l] + 4; j++) begin
                cam_href  = (j < ln_len[l]);
                cam_data  = (j < ln_len[l]) ? ln_b[l][j] : 8'h00;
                fifo_full = ln_full[l][j];
                if (drop_en && l == 0 && j == 2) capture_en = 1'b0;
                tick;
            end
            fifo_full = 1'b0;
            cam_href  = 1'b0;
        end
        cam_vsync = 1'b1;
        repeat (6) tick;
        model_frame_body;
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".nwrites"}, d, act_q[d].size(), exp_q[d].size());
            for (int i = 0; i < act_q[d].size() && i < exp_q[d].size(); i++)
                chk({tag, ".data"}, d, act_q[d][i], exp_q[d][i]);
            chk({tag, ".frame_count"}, d, fc[d], m_fc[d]);
            chk({tag, ".line_count"}, d, lc[d], m_lc[d]);
            chk({tag, ".overflow"}, d, ovf[d], m_ovf[d]);
            chk({tag, ".line_error"}, d, lerr[d], m_lerr[d]);
            chk({tag, ".frame_done_pulses"}, d, done_cnt[d], m_done[d]);
            chk({tag, ".frame_active"}, d, fa[d], 0);
            act_q[d].delete();
            exp_q[d].delete();
        end
    endtask

    task automatic set_fixed_lines(input int len0, input int len1, input int full_off);
        nlines = 2;
        ln_len[0] = len0;
        ln_len[1] = len1;
        for (int l = 0; l < 4; l++)
            for (int j = 0; j < 16; j++) begin
                ln_b[l][j]    = 8'((j + 1) * 17);
                ln_full[l][j] = 0;
            end
        if (full_off >= 0) ln_full[0][full_off] = 1;
    endtask

    initial begin
        int lens [6];
        lens = '{8, 8, 8, 7, 6, 10};

        tbl[0] = '{8, 8, -1, 1, 0, 0, 8, 0, 0, 0};
        tbl[1] = '{8, 8, -1, 1, 0, 0, 8, 0, 0, 0};
        tbl[2] = '{8, 8, -1, 1, 0, 0, 8, 8, 0, 0};
        tbl[3] = '{8, 8,  6, 1, 0, 0, 7, 7, 1, 0};
        tbl[4] = '{8, 8, -1, 1, 0, 1, 8, 8, 0, 0};
        tbl[5] = '{7, 8, -1, 1, 0, 0, 7, 7, 0, 1};
        tbl[6] = '{8, 8, -1, 1, 0, 1, 8, 8, 0, 0};
        tbl[7] = '{8, 8, -1, 1, 1, 0, 8, 8, 0, 0};
        tbl[8] = '{8, 8, -1, 0, 0, 0, 0, 0, 0, 0};
        tbl[9] = '{8, 8, -1, 1, 0, 0, 8, 0, 0, 0};

        model_reset;
        repeat (3) tick;
        for (int d = 0; d < 2; d++) begin
            chk("rst.fifo_write", d, fw[d], 0);
            chk("rst.fifo_data", d, fd[d], 0);
            chk("rst.frame_active", d, fa[d], 0);
            chk("rst.frame_done", d, fdone[d], 0);
            chk("rst.frame_count", d, fc[d], 0);
            chk("rst.line_count", d, lc[d], 0);
            chk("rst.overflow", d, ovf[d], 0);
            chk("rst.line_error", d, lerr[d], 0);
        end
        rst_n = 1'b1;
        tick;

        // directed frame table
        for (int i = 0; i < 10; i++) begin
            set_fixed_lines(tbl[i].len0, tbl[i].len1, tbl[i].full_off);
            if (tbl[i].clr) pulse_clr;
            drive_frame(tbl[i].en, tbl[i].drop);
            chk($sformatf("vec%0d.tbl_writes", i), 0, act_q[0].size(), tbl[i].wr_a);
            chk($sformatf("vec%0d.tbl_writes", i), 1, act_q[1].size(), tbl[i].wr_b);
            chk($sformatf("vec%0d.tbl_overflow", i), 0, ovf[0], tbl[i].ovf);
            chk($sformatf("vec%0d.tbl_line_error", i), 0, lerr[0], tbl[i].lerr);
            check_all($sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a line
        capture_en = 1'b1;
        tick;
        tick;
        cam_vsync = 1'b0;
        repeat (3) tick;
        for (int j = 0; j < 5; j++) begin
            cam_href = 1'b1;
            cam_data = 8'(8'hA1 + j);
            tick;
        end
        chk("midrst.pre_frame_active", 0, fa[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.fifo_write", 0, fw[0], 0);
        chk("midrst.fifo_data", 0, fd[0], 0);
        chk("midrst.frame_active", 0, fa[0], 0);
        chk("midrst.frame_count", 0, fc[0], 0);
        chk("midrst.line_count", 0, lc[0], 0);
        model_reset;
        tick;
        tick;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cam_data = 8'(8'hB1 + j);
            tick;
        end
        cam_href = 1'b0;
        repeat (4) tick;
        cam_vsync = 1'b1;
        repeat (6) tick;
        chk("midrst.no_writes", 0, act_q[0].size(), 0);
        chk("midrst.no_writes", 1, act_q[1].size(), 0);
        set_fixed_lines(8, 8, -1);
        drive_frame(1'b1, 1'b0);
        chk("postrst.frame_count", 0, fc[0], 1);
        check_all("postrst");

        // randomized frames against the model
        for (int r = 0; r < 8; r++) begin
            nlines = $urandom_range(1, 3);
            for (int l = 0; l < 4; l++) begin
                ln_len[l] = lens[$urandom_range(0, 5)];
                for (int j = 0; j < 16; j++) begin
                    ln_b[l][j]    = 8'($urandom);
                    ln_full[l][j] = ($urandom_range(0, 7) == 0);
                end
            end
            if ($urandom_range(0, 3) == 0) pulse_clr;
            drive_frame(1'b1, 1'b0);
            check_all($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Camera-side capture stage that feeds the dual-clock pixel FIFO; runs entirely in the sensor pixel-clock domain.
- Samples the 8-bit DVP bus (VSYNC/HREF/D[7:0]), pairs bytes into 16-bit RGB565 words and drives the FIFO write port (write/data_write, observing full).
- Provides frame/line bookkeeping, a startup frame skip and sticky error flags for the control CPU.

Parameters:
- IMG_WIDTH, 640, active pixels (16-bit words) per line.
- IMG_HEIGHT, 480, active lines per frame.
- SKIP_FRAMES, 2, complete frames discarded after reset or capture_en rise (sensor settle); 0 allowed.
- CNT_W, 11, width of the pixel and line counters.

Ports:
- clk  in  1  sensor pixel clock (PCLK), rising edge.
- rst_n  in  1  asynchronous active-low reset.
- capture_en  in  1  capture enable, level.
- cam_vsync  in  1  frame sync, high = vertical blanking.
- cam_href  in  1  line valid, high = active bytes.
- cam_data  in  8  sensor data byte.
- fifo_full  in  1  FIFO full flag.
- clr_status  in  1  one-cycle pulse, clears overflow and line_error.
- fifo_write  out  1  FIFO write strobe.
- fifo_data  out  16  packed pixel {first byte, second byte}.
- frame_active  out  1  high while a captured frame is in progress.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_count  out  16  captured frames since reset, wraps at 65535->0.
- line_count  out  CNT_W  lines completed in current or last frame.
- overflow  out  1  sticky: a pixel was dropped because fifo_full was high.
- line_error  out  1  sticky: a line ended with pixel count != IMG_WIDTH or an odd byte.

Behaviour:
- Reset: all outputs 0; state SYNC; byte phase 0; counters 0. Asynchronous assertion takes effect immediately, including mid-frame; no partial pixel is written after reset release.
- Input stage: cam_vsync, cam_href, cam_data registered once; all logic uses the registered copies; edges are detected on registered vsync/href.
- States:
  - SYNC: wait for vsync falling edge with capture_en=1 -> SKIP if SKIP_FRAMES>0, else ACTIVE.
  - SKIP: count vsync falling edges. The frame beginning at the entry edge counts as the first skipped frame; on the edge that ends the SKIP_FRAMES-th skipped frame -> ACTIVE, and that frame is captured.
  - ACTIVE: capture; frame_active=1. On vsync rising edge -> frame end, then -> WAIT.
  - WAIT: on vsync falling edge -> ACTIVE if capture_en=1, else SYNC.
  - capture_en low mid-frame does not abort: the current frame completes.
- Byte pairing (ACTIVE, href_q=1): phase 0 latches the high byte; phase 1 forms the pixel. Phase resets to 0 at every href rising edge.
- Write timing: fifo_write high exactly one cycle, starting the clock after the edge that registers the second byte. fifo_data is valid in the same cycle and held until the next write.
- Full handling: if fifo_full=1 in the cycle the write would assert, the write is suppressed, the pixel is dropped, overflow is set and the pixel counter still advances.
- Line end (href falling edge in ACTIVE):
  - line_count increments, saturating at 2^CNT_W-1.
  - line_error is set if the pixel counter != IMG_WIDTH or phase=1; the odd byte is discarded.
  - Pixel counter clears.
  - Pixels beyond IMG_WIDTH in a line are still written.
- Frame end (vsync rising edge in ACTIVE):
  - frame_done pulses for 1 cycle; frame_count increments; frame_active falls the same cycle.
  - line_count holds until the next frame start, then clears.
  - A line-count mismatch against IMG_HEIGHT does not set line_error.
- clr_status: clears both sticky flags next cycle. A simultaneous set event wins.
- Latency: data byte on pins to fifo_write = 3 clocks for the second byte.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, SKIP_FRAMES=0. One frame, bytes 0x11..0x88 per line -> 4 writes per line: 0x1122, 0x3344, 0x5566, 0x7788. Then frame_done pulse, frame_count=1, line_count=2, no sticky flags.
- SKIP_FRAMES=2, 3 frames driven -> zero writes during frames 1-2. Frame 3 gives 8 writes, frame_count=1.
- fifo_full held high during 2nd pixel of line 1 -> 7 writes. Pixel 0x3344 missing, overflow=1. clr_status pulse -> overflow=0.
- Line of 7 bytes -> 3 writes, odd byte dropped, line_error=1. Next line of 8 bytes is written normally.
- rst_n pulsed low mid-line -> outputs 0 immediately. After release, no writes until a full vsync fall; next frame is captured cleanly.
- capture_en dropped mid-frame 1 -> frame 1 completes with 8 writes and frame_done. Frame 2 gives no writes, state SYNC.
